// File: rtl/bp_be_pkg.sv
// Shared types for the dual-issue scheduler: configuration selector,
// issue packet layout and scheduler state encoding.
package bp_be_pkg;

   typedef enum logic [0:0] {e_bp_default_cfg} bp_params_e;

   localparam int reg_addr_width_gp = 5;

   typedef struct packed {
      logic [reg_addr_width_gp-1:0] rd;
      logic [reg_addr_width_gp-1:0] rs1;
      logic [reg_addr_width_gp-1:0] rs2;
      logic                         rd_w_v;
      logic                         mem_v;
      logic                         long_v;
   } issue_pkt_s;

   typedef enum logic [0:0] {e_pair, e_split} bp_be_di_sched_state_e;

   // Register address width for a given configuration
   function automatic int bp_reg_addr_width(bp_params_e cfg);
      case (cfg)
         e_bp_default_cfg: return reg_addr_width_gp;
         default:          return reg_addr_width_gp;
      endcase
   endfunction

endpackage

// File: rtl/bp_be_di_hazard_mask.sv
// Per-slot hazard generation: masks scoreboard matches against x0 and
// non-writing destinations; slot 1 also sees structural conflicts with slot 0.
module bp_be_di_hazard_mask
   import bp_be_pkg::*;
#(
   parameter int slot_p = 0
) (
   input  issue_pkt_s  pkt_i,
   input  issue_pkt_s  pkt0_i,
   input  logic [1:0]  rs_match_i,
   input  logic        rd_match_i,
   output logic        hz_o
);

   logic w_rs1_hz, w_rs2_hz, w_rd_hz, w_struct_hz;

   // Ignore reads of x0 and writes that never land in the register file
   always_comb begin
      w_rs1_hz    = rs_match_i[0] & (pkt_i.rs1 != '0);
      w_rs2_hz    = rs_match_i[1] & (pkt_i.rs2 != '0);
      w_rd_hz     = rd_match_i & pkt_i.rd_w_v & (pkt_i.rd != '0);
      w_struct_hz = (pkt_i.mem_v & pkt0_i.mem_v) | (pkt_i.long_v & pkt0_i.long_v);
      hz_o        = w_rs1_hz | w_rs2_hz | w_rd_hz | ((slot_p == 1) ? w_struct_hz : 1'b0);
   end

endmodule

// File: rtl/bp_be_di_issue_scheduler.sv
// Dual-issue scheduler: dispatches an instruction pair, splitting it through
// a one-entry hold register when slot 1 is hazarded.
// Optional: define BP_BE_DI_SPLIT_CNT_EN to add split_cnt_o, a count of
// pair-to-split transitions.
module bp_be_di_issue_scheduler
   import bp_be_pkg::*;
#(
   parameter bp_params_e bp_params_p = e_bp_default_cfg,
   localparam int reg_addr_width_lp = bp_reg_addr_width(bp_params_p)
) (
   input  logic                                clk_i,
   input  logic                                reset_i,
   input  logic [1:0]                          issue_v_i,
   input  issue_pkt_s [1:0]                    issue_pkt_i,
   output logic                                issue_ready_o,
   input  logic                                flush_i,
   input  logic                                dispatch_ready_i,
   output logic [1:0]                          dispatch_v_o,
   output issue_pkt_s [1:0]                    dispatch_pkt_o,
   output logic [1:0][reg_addr_width_lp-1:0]   sb_rs_o1,
   output logic [1:0][reg_addr_width_lp-1:0]   sb_rs_o2,
   output logic [reg_addr_width_lp-1:0]        sb_rd_o1,
   output logic [reg_addr_width_lp-1:0]        sb_rd_o2,
   input  logic [1:0]                          sb_rs_match_i1,
   input  logic [1:0]                          sb_rs_match_i2,
   input  logic                                sb_rd_match_i1,
   input  logic                                sb_rd_match_i2,
   output logic                                score_v_o,
   output logic                                score_v_o2,
   output logic [reg_addr_width_lp-1:0]        score_rd_o,
   output logic [reg_addr_width_lp-1:0]        score_rd_o2
`ifdef BP_BE_DI_SPLIT_CNT_EN
   ,output logic [31:0]                        split_cnt_o
`endif
);

   bp_be_di_sched_state_e r_state;
   issue_pkt_s            r_hold;
   logic                  r_hold_v;

   logic       w_split, w_v0, w_go, w_hz0, w_hz1, w_d0, w_d1, w_latch;
   issue_pkt_s w_pkt0, w_pkt1;

   // Slot 0 is the held instruction while split, otherwise the incoming oldest
   always_comb begin
      w_split = (r_state == e_split);
      w_pkt0  = w_split ? r_hold : issue_pkt_i[0];
      w_pkt1  = issue_pkt_i[1];
      w_v0    = w_split ? r_hold_v : issue_v_i[0];
   end

   bp_be_di_hazard_mask #(.slot_p(0)) u_hz0 (
      .pkt_i      (w_pkt0),
      .pkt0_i     (w_pkt0),
      .rs_match_i (sb_rs_match_i1),
      .rd_match_i (sb_rd_match_i1),
      .hz_o       (w_hz0)
   );

   bp_be_di_hazard_mask #(.slot_p(1)) u_hz1 (
      .pkt_i      (w_pkt1),
      .pkt0_i     (w_pkt0),
      .rs_match_i (sb_rs_match_i2),
      .rd_match_i (sb_rd_match_i2),
      .hz_o       (w_hz1)
   );

   // Dispatch decision; slot 1 only ever goes alongside slot 0 from a fresh pair
   always_comb begin
      w_go    = dispatch_ready_i & ~flush_i & ~reset_i;
      w_d0    = w_go & w_v0 & ~w_hz0;
      w_d1    = w_d0 & ~w_split & issue_v_i[1] & ~w_hz1;
      w_latch = w_d0 & ~w_split & issue_v_i[1] & w_hz1;

      issue_ready_o  = ~reset_i & (flush_i | (w_d0 & ~w_split));
      dispatch_v_o   = {w_d1, w_d0};
      dispatch_pkt_o = {w_pkt1, w_pkt0};

      sb_rs_o1 = {w_pkt0.rs2, w_pkt0.rs1};
      sb_rs_o2 = {w_pkt1.rs2, w_pkt1.rs1};
      sb_rd_o1 = w_pkt0.rd;
      sb_rd_o2 = w_pkt1.rd;

      score_v_o   = w_d0 & w_pkt0.rd_w_v & (w_pkt0.rd != '0) & w_pkt0.long_v;
      score_v_o2  = w_d1 & w_pkt1.rd_w_v & (w_pkt1.rd != '0) & w_pkt1.long_v;
      score_rd_o  = w_pkt0.rd;
      score_rd_o2 = w_pkt1.rd;
   end

   // Pair/split state and the hold register; flush and reset drop the held entry
   always_ff @(posedge clk_i) begin
      if (reset_i || flush_i) begin
         r_state  <= e_pair;
         r_hold_v <= 1'b0;
         if (reset_i) r_hold <= '0;
      end else if (w_latch) begin
         r_state  <= e_split;
         r_hold   <= w_pkt1;
         r_hold_v <= 1'b1;
      end else if (w_split && w_d0) begin
         r_state  <= e_pair;
         r_hold_v <= 1'b0;
      end
   end

`ifdef BP_BE_DI_SPLIT_CNT_EN
   // Count pair-to-split transitions; a latch never happens under flush
   always_ff @(posedge clk_i) begin
      if (reset_i)      split_cnt_o <= '0;
      else if (w_latch) split_cnt_o <= split_cnt_o + 32'd1;
   end
`endif

endmodule

// File: tb/tb_bp_be_di_issue_scheduler.sv
// Scoreboard-driven bench for the dual-issue scheduler.
module tb_bp_be_di_issue_scheduler;
   import bp_be_pkg::*;

   logic             clk_i = 0;
   logic             reset_i;
   logic [1:0]       issue_v_i;
   issue_pkt_s [1:0] issue_pkt_i;
   logic             issue_ready_o;
   logic             flush_i;
   logic             dispatch_ready_i;
   logic [1:0]       dispatch_v_o;
   issue_pkt_s [1:0] dispatch_pkt_o;
   logic [1:0][4:0]  sb_rs_o1, sb_rs_o2;
   logic [4:0]       sb_rd_o1, sb_rd_o2;
   logic [1:0]       sb_rs_match_i1, sb_rs_match_i2;
   logic             sb_rd_match_i1, sb_rd_match_i2;
   logic             score_v_o, score_v_o2;
   logic [4:0]       score_rd_o, score_rd_o2;
`ifdef BP_BE_DI_SPLIT_CNT_EN
   logic [31:0]      split_cnt_o;
`endif

   int pass_cnt = 0;
   int total_cnt = 0;

   always #5 clk_i = ~clk_i;

   bp_be_di_issue_scheduler dut (
      .clk_i(clk_i), .reset_i(reset_i), .issue_v_i(issue_v_i), .issue_pkt_i(issue_pkt_i),
      .issue_ready_o(issue_ready_o), .flush_i(flush_i), .dispatch_ready_i(dispatch_ready_i),
      .dispatch_v_o(dispatch_v_o), .dispatch_pkt_o(dispatch_pkt_o),
      .sb_rs_o1(sb_rs_o1), .sb_rs_o2(sb_rs_o2), .sb_rd_o1(sb_rd_o1), .sb_rd_o2(sb_rd_o2),
      .sb_rs_match_i1(sb_rs_match_i1), .sb_rs_match_i2(sb_rs_match_i2),
      .sb_rd_match_i1(sb_rd_match_i1), .sb_rd_match_i2(sb_rd_match_i2),
      .score_v_o(score_v_o), .score_v_o2(score_v_o2),
      .score_rd_o(score_rd_o), .score_rd_o2(score_rd_o2)
`ifdef BP_BE_DI_SPLIT_CNT_EN
      ,.split_cnt_o(split_cnt_o)
`endif
   );

   typedef struct {
      logic [1:0] v;
      issue_pkt_s p0, p1;
      logic [1:0] m1, m2;
      logic       r1, r2, dr, fl, rst;
   } stim_t;

   typedef struct {
      logic [1:0] dv;
      logic       rdy, s0, s1;
      logic [4:0] rd0, srd2;
   } exp_t;

   exp_t q[$];

   function automatic issue_pkt_s mk(int rd, int rs1, int rs2, bit rdw, bit mem, bit lng);
      issue_pkt_s p;
      p.rd = rd[4:0]; p.rs1 = rs1[4:0]; p.rs2 = rs2[4:0];
      p.rd_w_v = rdw; p.mem_v = mem; p.long_v = lng;
      return p;
   endfunction

   function automatic stim_t st(logic [1:0] v, issue_pkt_s p0, issue_pkt_s p1,
                                logic [1:0] m1, logic [1:0] m2, logic r1,
                                logic dr, logic fl, logic rst);
      stim_t s;
      s.v = v; s.p0 = p0; s.p1 = p1; s.m1 = m1; s.m2 = m2;
      s.r1 = r1; s.r2 = 1'b0; s.dr = dr; s.fl = fl; s.rst = rst;
      return s;
   endfunction

   function automatic exp_t ex(logic [1:0] dv, logic rdy, logic s0, logic s1, int rd0, int srd2);
      exp_t e;
      e.dv = dv; e.rdy = rdy; e.s0 = s0; e.s1 = s1; e.rd0 = rd0[4:0]; e.srd2 = srd2[4:0];
      return e;
   endfunction

   function automatic exp_t obs();
      exp_t g;
      g.dv = dispatch_v_o; g.rdy = issue_ready_o; g.s0 = score_v_o; g.s1 = score_v_o2;
      g.rd0 = dispatch_pkt_o[0].rd; g.srd2 = score_rd_o2;
      return g;
   endfunction

   // Apply one cycle of stimulus just after the rising edge and queue its expectation
   task automatic drive(input stim_t s, input exp_t e);
      @(posedge clk_i); #1;
      issue_v_i = s.v; issue_pkt_i[0] = s.p0; issue_pkt_i[1] = s.p1;
      sb_rs_match_i1 = s.m1; sb_rs_match_i2 = s.m2;
      sb_rd_match_i1 = s.r1; sb_rd_match_i2 = s.r2;
      dispatch_ready_i = s.dr; flush_i = s.fl; reset_i = s.rst;
      q.push_back(e);
   endtask

   issue_pkt_s nop = '0;

   task automatic test_reset();
      stim_t s[$]; exp_t e[$]; exp_t x, g;
      s.push_back(st(2'b11, mk(1,2,3,1,0,1), mk(4,5,6,1,0,0), 0, 0, 0, 1, 0, 1)); e.push_back(ex(2'b00,0,0,0,0,0));
      s.push_back(st(2'b11, mk(1,2,3,1,0,1), mk(4,5,6,1,0,0), 0, 0, 0, 1, 0, 1)); e.push_back(ex(2'b00,0,0,0,0,0));
      foreach (s[i]) begin
         drive(s[i], e[i]); @(negedge clk_i); x = q.pop_front(); g = obs(); total_cnt++;
         if (g.dv !== x.dv || g.rdy !== x.rdy || g.s0 !== x.s0 || g.s1 !== x.s1)
            $display("FAIL reset[%0d]: got dv=%b rdy=%b s0=%b s1=%b, want dv=%b rdy=%b s0=%b s1=%b", i, g.dv, g.rdy, g.s0, g.s1, x.dv, x.rdy, x.s0, x.s1);
         else pass_cnt++;
      end
`ifdef BP_BE_DI_SPLIT_CNT_EN
      total_cnt++;
      if (split_cnt_o !== 32'd0) $display("FAIL reset_cnt: got %0d want 0", split_cnt_o); else pass_cnt++;
`endif
   endtask

   task automatic test_struct();
      stim_t s[$]; exp_t e[$]; exp_t x, g;
      s.push_back(st(2'b11, mk(12,1,2,1,1,0), mk(13,3,4,1,1,0), 0, 0, 0, 1, 0, 0)); e.push_back(ex(2'b01,1,0,0,12,0));
      s.push_back(st(2'b00, nop, nop, 0, 0, 0, 1, 0, 0));                          e.push_back(ex(2'b01,0,0,0,13,0));
      foreach (s[i]) begin
         drive(s[i], e[i]); @(negedge clk_i); x = q.pop_front(); g = obs(); total_cnt++;
         if (g.dv !== x.dv || g.rdy !== x.rdy || g.s0 !== x.s0 || g.s1 !== x.s1 || (x.dv[0] && g.rd0 !== x.rd0))
            $display("FAIL struct[%0d]: got dv=%b rdy=%b rd0=%0d, want dv=%b rdy=%b rd0=%0d", i, g.dv, g.rdy, g.rd0, x.dv, x.rdy, x.rd0);
         else pass_cnt++;
`ifdef BP_BE_DI_SPLIT_CNT_EN
         if (i == 1) begin
            total_cnt++;
            if (split_cnt_o !== 32'd1) $display("FAIL split_cnt: got %0d want 1", split_cnt_o); else pass_cnt++;
         end
`endif
      end
   endtask

   task automatic test_indep();
      stim_t s[$]; exp_t e[$]; exp_t x, g;
      s.push_back(st(2'b11, mk(1,2,3,1,0,0), mk(4,5,6,1,0,0), 0, 0, 0, 1, 0, 0)); e.push_back(ex(2'b11,1,0,0,1,0));
      s.push_back(st(2'b01, mk(7,8,9,1,0,0), nop, 0, 0, 0, 1, 0, 0));             e.push_back(ex(2'b01,1,0,0,7,0));
      s.push_back(st(2'b00, nop, nop, 0, 0, 0, 1, 0, 0));                         e.push_back(ex(2'b00,0,0,0,0,0));
      foreach (s[i]) begin
         drive(s[i], e[i]); @(negedge clk_i); x = q.pop_front(); g = obs(); total_cnt++;
         if (g.dv !== x.dv || g.rdy !== x.rdy || g.s0 !== x.s0 || g.s1 !== x.s1 || (x.dv[0] && g.rd0 !== x.rd0))
            $display("FAIL indep[%0d]: got dv=%b rdy=%b rd0=%0d, want dv=%b rdy=%b rd0=%0d", i, g.dv, g.rdy, g.rd0, x.dv, x.rdy, x.rd0);
         else pass_cnt++;
      end
   endtask

   task automatic test_raw();
      stim_t s[$]; exp_t e[$]; exp_t x, g;
      s.push_back(st(2'b11, mk(1,2,3,1,0,0), mk(4,1,6,1,0,0), 0, 2'b01, 0, 1, 0, 0)); e.push_back(ex(2'b01,1,0,0,1,0));
      s.push_back(st(2'b11, mk(10,2,3,1,0,0), mk(11,5,6,1,0,0), 0, 0, 0, 1, 0, 0));  e.push_back(ex(2'b01,0,0,0,4,0));
      s.push_back(st(2'b11, mk(10,2,3,1,0,0), mk(11,5,6,1,0,0), 0, 0, 0, 1, 0, 0));  e.push_back(ex(2'b11,1,0,0,10,0));
      foreach (s[i]) begin
         drive(s[i], e[i]); @(negedge clk_i); x = q.pop_front(); g = obs(); total_cnt++;
         if (g.dv !== x.dv || g.rdy !== x.rdy || g.s0 !== x.s0 || g.s1 !== x.s1 || (x.dv[0] && g.rd0 !== x.rd0))
            $display("FAIL raw[%0d]: got dv=%b rdy=%b rd0=%0d, want dv=%b rdy=%b rd0=%0d", i, g.dv, g.rdy, g.rd0, x.dv, x.rdy, x.rd0);
         else pass_cnt++;
      end
   endtask

   task automatic test_slot0_hazard();
      stim_t s[$]; exp_t e[$]; exp_t x, g;
      s.push_back(st(2'b01, mk(8,7,0,1,0,0), nop, 2'b01, 0, 0, 1, 0, 0)); e.push_back(ex(2'b00,0,0,0,0,0));
      s.push_back(st(2'b01, mk(8,7,0,1,0,0), nop, 2'b01, 0, 0, 1, 0, 0)); e.push_back(ex(2'b00,0,0,0,0,0));
      s.push_back(st(2'b01, mk(8,7,0,1,0,0), nop, 2'b00, 0, 0, 1, 0, 0)); e.push_back(ex(2'b01,1,0,0,8,0));
      s.push_back(st(2'b01, mk(8,0,0,1,0,0), nop, 2'b01, 0, 0, 1, 0, 0)); e.push_back(ex(2'b01,1,0,0,8,0));
      s.push_back(st(2'b01, mk(6,1,2,0,0,0), nop, 2'b00, 0, 1, 1, 0, 0)); e.push_back(ex(2'b01,1,0,0,6,0));
      s.push_back(st(2'b01, mk(6,1,2,1,0,0), nop, 2'b00, 0, 1, 1, 0, 0)); e.push_back(ex(2'b00,0,0,0,0,0));
      s.push_back(st(2'b01, mk(0,1,2,1,0,0), nop, 2'b00, 0, 1, 1, 0, 0)); e.push_back(ex(2'b01,1,0,0,0,0));
      foreach (s[i]) begin
         drive(s[i], e[i]); @(negedge clk_i); x = q.pop_front(); g = obs(); total_cnt++;
         if (g.dv !== x.dv || g.rdy !== x.rdy || g.s0 !== x.s0 || g.s1 !== x.s1 || (x.dv[0] && g.rd0 !== x.rd0))
            $display("FAIL hz0[%0d]: got dv=%b rdy=%b rd0=%0d, want dv=%b rdy=%b rd0=%0d", i, g.dv, g.rdy, g.rd0, x.dv, x.rdy, x.rd0);
         else pass_cnt++;
      end
   endtask

   task automatic test_flush_split();
      stim_t s[$]; exp_t e[$]; exp_t x, g;
      s.push_back(st(2'b11, mk(2,1,0,1,0,1), mk(3,4,0,1,0,1), 0, 0, 0, 1, 0, 0)); e.push_back(ex(2'b01,1,1,0,2,0));
      s.push_back(st(2'b11, nop, nop, 0, 0, 0, 0, 0, 0));                         e.push_back(ex(2'b00,0,0,0,0,0));
      s.push_back(st(2'b11, nop, nop, 0, 0, 0, 1, 1, 0));                         e.push_back(ex(2'b00,1,0,0,0,0));
      s.push_back(st(2'b00, nop, nop, 0, 0, 0, 1, 0, 0));                         e.push_back(ex(2'b00,0,0,0,0,0));
      s.push_back(st(2'b11, mk(12,1,2,1,1,0), mk(13,3,4,1,1,0), 0, 0, 0, 1, 0, 0)); e.push_back(ex(2'b01,1,0,0,12,0));
      s.push_back(st(2'b11, nop, nop, 0, 0, 0, 1, 0, 1));                         e.push_back(ex(2'b00,0,0,0,0,0));
      s.push_back(st(2'b00, nop, nop, 0, 0, 0, 1, 0, 0));                         e.push_back(ex(2'b00,0,0,0,0,0));
      s.push_back(st(2'b01, mk(5,0,0,1,0,0), nop, 0, 0, 0, 1, 0, 0));             e.push_back(ex(2'b01,1,0,0,5,0));
      foreach (s[i]) begin
         drive(s[i], e[i]); @(negedge clk_i); x = q.pop_front(); g = obs(); total_cnt++;
         if (g.dv !== x.dv || g.rdy !== x.rdy || g.s0 !== x.s0 || g.s1 !== x.s1 || (x.dv[0] && g.rd0 !== x.rd0))
            $display("FAIL flush[%0d]: got dv=%b rdy=%b s0=%b rd0=%0d, want dv=%b rdy=%b s0=%b rd0=%0d", i, g.dv, g.rdy, g.s0, g.rd0, x.dv, x.rdy, x.s0, x.rd0);
         else pass_cnt++;
      end
   endtask

   task automatic test_score();
      stim_t s[$]; exp_t e[$]; exp_t x, g;
      s.push_back(st(2'b11, mk(3,1,2,1,0,0), mk(9,10,0,1,1,1), 0, 0, 0, 1, 0, 0)); e.push_back(ex(2'b11,1,0,1,3,9));
      s.push_back(st(2'b11, mk(3,1,2,1,0,0), mk(0,10,0,1,1,1), 0, 0, 0, 1, 0, 0)); e.push_back(ex(2'b11,1,0,0,3,0));
      s.push_back(st(2'b01, mk(9,1,0,1,1,1), nop, 0, 0, 0, 1, 0, 0));             e.push_back(ex(2'b01,1,1,0,9,0));
      s.push_back(st(2'b01, mk(9,1,0,1,1,1), nop, 0, 0, 0, 0, 0, 0));             e.push_back(ex(2'b00,0,0,0,0,0));
      foreach (s[i]) begin
         drive(s[i], e[i]); @(negedge clk_i); x = q.pop_front(); g = obs(); total_cnt++;
         if (g.dv !== x.dv || g.rdy !== x.rdy || g.s0 !== x.s0 || g.s1 !== x.s1 ||
             (x.dv[0] && g.rd0 !== x.rd0) || (x.s1 && g.srd2 !== x.srd2))
            $display("FAIL score[%0d]: got dv=%b s0=%b s1=%b rd2=%0d, want dv=%b s0=%b s1=%b rd2=%0d", i, g.dv, g.s0, g.s1, g.srd2, x.dv, x.s0, x.s1, x.srd2);
         else pass_cnt++;
      end
   endtask

   initial begin
      reset_i = 1; flush_i = 0; dispatch_ready_i = 0; issue_v_i = 0; issue_pkt_i = '0;
      sb_rs_match_i1 = 0; sb_rs_match_i2 = 0; sb_rd_match_i1 = 0; sb_rd_match_i2 = 0;
      test_reset();
      test_struct();
      test_indep();
      test_raw();
      test_slot0_hazard();
      test_flush_split();
      test_score();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
